// File: rtl/conv_out_packer_if.sv
// Accumulator stream and packed four-lane pixel output of the convolution output stage.
// The packer owns the slave side; the convolution core / bench owns the master side.
interface conv_out_packer_if #(
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 12
);
    logic                     i_acc_valid;
    logic signed [ACC_W-1:0]  i_acc_data;
    logic                     o_acc_ready;

    logic [7:0]               o_out_data1;
    logic [7:0]               o_out_data2;
    logic [7:0]               o_out_data3;
    logic [7:0]               o_out_data4;
    logic [ADDR_W-1:0]        o_out_addr1;
    logic [ADDR_W-1:0]        o_out_addr2;
    logic [ADDR_W-1:0]        o_out_addr3;
    logic [ADDR_W-1:0]        o_out_addr4;
    logic                     o_out_valid1;
    logic                     o_out_valid2;
    logic                     o_out_valid3;
    logic                     o_out_valid4;
    logic                     o_exe_finish;

    modport master (
        output i_acc_valid, i_acc_data,
        input  o_acc_ready,
        input  o_out_data1, o_out_data2, o_out_data3, o_out_data4,
        input  o_out_addr1, o_out_addr2, o_out_addr3, o_out_addr4,
        input  o_out_valid1, o_out_valid2, o_out_valid3, o_out_valid4,
        input  o_exe_finish
    );

    modport slave (
        input  i_acc_valid, i_acc_data,
        output o_acc_ready,
        output o_out_data1, o_out_data2, o_out_data3, o_out_data4,
        output o_out_addr1, o_out_addr2, o_out_addr3, o_out_addr4,
        output o_out_valid1, o_out_valid2, o_out_valid3, o_out_valid4,
        output o_exe_finish
    );
endinterface

// File: rtl/conv_out_packer.sv
// Convolution output stage: shift/clamp MAC sums to 8-bit pixels and pack them four per beat.
// Optional feature macro CONV_OUT_ROUND_EN: round half up before the shift (default truncates).
module conv_out_packer #(
    parameter int ACC_W  = 24,
    parameter int FRAC_W = 7,
    parameter int ADDR_W = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cfg_valid,
    input  logic [6:0]         i_out_dim,
    conv_out_packer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

`ifdef CONV_OUT_ROUND_EN
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) << (FRAC_W - 1);
`else
    localparam logic signed [ACC_W:0] RND = '0;
`endif
    localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W+1)'(255);

    state_t                    state;
    state_t                    state_nxt;
    logic [13:0]               total;
    logic [13:0]               idx;
    logic [1:0]                lane;
    logic                      xfer;
    logic                      last;
    logic                      group_done;
    logic                      start;

    logic signed [ACC_W:0]     acc_ext;
    logic signed [ACC_W:0]     acc_sum;
    logic signed [ACC_W:0]     acc_shr;
    logic [7:0]                pix;

    logic [3:0][7:0]           col_data;
    logic [3:0][ADDR_W-1:0]    col_addr;
    logic [3:0][7:0]           out_data;
    logic [3:0][ADDR_W-1:0]    out_addr;
    logic [3:0]                out_valid;

    // One extra bit of headroom so adding the rounding constant can never overflow.
    assign acc_ext = {bus.i_acc_data[ACC_W-1], bus.i_acc_data};
    assign acc_sum = acc_ext + RND;
    assign acc_shr = acc_sum >>> FRAC_W;

    always_comb begin
        pix = acc_shr[7:0];
        if (acc_shr[ACC_W]) begin
            pix = 8'd0;
        end else if (acc_shr > PIX_MAX) begin
            pix = 8'd255;
        end
    end

    assign start      = i_cfg_valid && (state == IDLE || state == DONE);
    assign xfer       = bus.i_acc_valid && (state == RUN);
    assign last       = (idx == total - 14'd1);
    assign lane       = idx[1:0];
    assign group_done = xfer && (lane == 2'd3 || last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_cfg_valid) state_nxt = RUN;
            RUN:     if (xfer && last) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    if (i_cfg_valid) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Collect bank fills lane by lane; the completing sample bypasses it straight into the
    // output bank, so a new group can start collecting on the very next transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            total     <= '0;
            idx       <= '0;
            col_data  <= '0;
            col_addr  <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= '0;
        end else begin
            if (start) begin
                total <= {7'd0, i_out_dim} * {7'd0, i_out_dim};
                idx   <= '0;
            end else if (xfer) begin
                idx <= idx + 14'd1;
            end

            if (xfer) begin
                col_data[lane] <= pix;
                col_addr[lane] <= idx[ADDR_W-1:0];
            end

            for (int i = 0; i < 4; i++) begin
                if (group_done && i <= int'(lane)) begin
                    out_valid[i] <= 1'b1;
                    out_data[i]  <= (i == int'(lane)) ? pix : col_data[i];
                    out_addr[i]  <= (i == int'(lane)) ? idx[ADDR_W-1:0] : col_addr[i];
                end else begin
                    out_valid[i] <= 1'b0;
                    out_data[i]  <= 8'd0;
                    out_addr[i]  <= '0;
                end
            end
        end
    end

    assign bus.o_acc_ready  = (state == RUN);
    assign bus.o_exe_finish = (state == DONE);

    assign bus.o_out_data1  = out_data[0];
    assign bus.o_out_data2  = out_data[1];
    assign bus.o_out_data3  = out_data[2];
    assign bus.o_out_data4  = out_data[3];
    assign bus.o_out_addr1  = out_addr[0];
    assign bus.o_out_addr2  = out_addr[1];
    assign bus.o_out_addr3  = out_addr[2];
    assign bus.o_out_addr4  = out_addr[3];
    assign bus.o_out_valid1 = out_valid[0];
    assign bus.o_out_valid2 = out_valid[1];
    assign bus.o_out_valid3 = out_valid[2];
    assign bus.o_out_valid4 = out_valid[3];

endmodule

// File: tb/tb_conv_out_packer.sv
// Directed bench for conv_out_packer: full map, clamp/rounding, partial group, gaps, reset, ignores.
// Define CONV_OUT_ROUND_EN here as well when the DUT is built with rounding.
module tb_conv_out_packer;

    localparam int ACC_W  = 24;
    localparam int ADDR_W = 12;
`ifdef CONV_OUT_ROUND_EN
    localparam logic [7:0] EXP_0X40 = 8'd1;
`else
    localparam logic [7:0] EXP_0X40 = 8'd0;
`endif

    typedef struct packed {
        logic [2:0]        lane;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic [6:0] out_dim;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int idle_bad = 0;
    int last_pulse_cyc = 0;
    int finish_rise_cyc = 0;
    int first_bad = 0;
    logic finish_d = 1'b0;

    pix_t                    pix_q[$];
    logic [3:0]              mask_q[$];
    logic signed [ACC_W-1:0] stim_q[$];
    int                      exp_q[$];

    logic [3:0]              vmask;
    logic [3:0][7:0]         ldata;
    logic [3:0][ADDR_W-1:0]  laddr;

    conv_out_packer_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

    conv_out_packer #(.ACC_W(ACC_W), .FRAC_W(7), .ADDR_W(ADDR_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_valid (cfg_valid),
        .i_out_dim   (out_dim),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    assign vmask = {bus.o_out_valid4, bus.o_out_valid3, bus.o_out_valid2, bus.o_out_valid1};
    assign ldata = {bus.o_out_data4, bus.o_out_data3, bus.o_out_data2, bus.o_out_data1};
    assign laddr = {bus.o_out_addr4, bus.o_out_addr3, bus.o_out_addr2, bus.o_out_addr1};

    always @(posedge clk) cyc <= cyc + 1;

    // Record every emitted pixel in lane order, and any idle lane that is not driving zero.
    always @(negedge clk) begin
        if (vmask != 4'd0) begin
            mask_q.push_back(vmask);
            last_pulse_cyc = cyc;
        end
        for (int l = 0; l < 4; l++) begin
            if (vmask[l]) begin
                pix_q.push_back(pix_t'{lane: 3'(l + 1), addr: laddr[l], data: ldata[l]});
            end else if (ldata[l] != 8'd0 || laddr[l] != '0) begin
                idle_bad++;
            end
        end
        if (bus.o_exe_finish && !finish_d) finish_rise_cyc = cyc;
        finish_d = bus.o_exe_finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int scan_stream();
        int bad = 0;
        for (int j = 0; j < pix_q.size() && j < exp_q.size(); j++) begin
            if (pix_q[j].lane != 3'(j % 4 + 1) || pix_q[j].addr != ADDR_W'(j) ||
                pix_q[j].data != 8'(exp_q[j])) begin
                if (bad == 0) first_bad = j;
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic clear_logs();
        pix_q.delete();
        mask_q.delete();
        stim_q.delete();
        exp_q.delete();
        idle_bad = 0;
    endtask

    task automatic do_cfg(input logic [6:0] dim);
        cfg_valid = 1'b1;
        out_dim   = dim;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    // Sends every entry of stim_q; with gaps set, random idle cycles are inserted between samples.
    task automatic applyStimulus(input bit gaps);
        int guard;
        foreach (stim_q[k]) begin
            while (gaps && $urandom_range(0, 1) == 1) begin
                bus.i_acc_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.i_acc_valid = 1'b1;
            bus.i_acc_data  = stim_q[k];
            @(negedge clk);
            guard = 0;
            while (!bus.o_acc_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!bus.o_acc_ready) begin
                checks++;
                errors++;
                $display("[TB] FAIL handshake_timeout: ready=%b required=1 at sample %0d", bus.o_acc_ready, k);
                bus.i_acc_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.i_acc_valid = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        int guard = 0;
        while (!bus.o_exe_finish && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (bus.o_exe_finish !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: finish=%b required=1", name, bus.o_exe_finish);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        out_dim = 7'd0;
        bus.i_acc_valid = 1'b0;
        bus.i_acc_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_acc_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ready: got %b required 0", bus.o_acc_ready);
        end
        checks++;
        if (vmask !== 4'd0) begin
            errors++; $display("[TB] FAIL reset_valid: got %b required 0000", vmask);
        end
        checks++;
        if (bus.o_exe_finish !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_finish: got %b required 0", bus.o_exe_finish);
        end
        checks++;
        if (ldata !== '0 || laddr !== '0) begin
            errors++; $display("[TB] FAIL reset_lanes: data=%h addr=%h required 0", ldata, laddr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_map();
        int bad;
        clear_logs();
        do_cfg(7'd64);
        for (int i = 0; i < 4096; i++) begin
            stim_q.push_back(ACC_W'(i << 7));
            exp_q.push_back(i > 255 ? 255 : i);
        end
        applyStimulus(1'b0);
        wait_finish("full_finish");
        checks++;
        if (pix_q.size() != 4096) begin
            errors++; $display("[TB] FAIL full_count: got %0d pixels required 4096", pix_q.size());
        end
        checks++;
        bad = scan_stream();
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL full_content: %0d bad, first idx %0d got lane %0d addr %0d data %0d required lane %0d addr %0d data %0d",
                     bad, first_bad, pix_q[first_bad].lane, pix_q[first_bad].addr, pix_q[first_bad].data,
                     first_bad % 4 + 1, first_bad, exp_q[first_bad]);
        end
        bad = 0;
        foreach (mask_q[m]) if (mask_q[m] !== 4'hF) bad++;
        checks++;
        if (mask_q.size() != 1024 || bad != 0) begin
            errors++; $display("[TB] FAIL full_pulses: got %0d pulses (%0d not all-lane) required 1024 all-lane", mask_q.size(), bad);
        end
        checks++;
        if (finish_rise_cyc != last_pulse_cyc + 1) begin
            errors++; $display("[TB] FAIL full_finish_timing: finish at cycle %0d required %0d", finish_rise_cyc, last_pulse_cyc + 1);
        end
        checks++;
        if (idle_bad != 0) begin
            errors++; $display("[TB] FAIL full_idle_lanes: got %0d nonzero idle lanes required 0", idle_bad);
        end
    endtask

    task automatic test_clamp_round();
        clear_logs();
        do_cfg(7'd2);
        @(negedge clk);
        checks++;
        if (bus.o_exe_finish !== 1'b0 || bus.o_acc_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL restart_from_done: finish=%b ready=%b required finish=0 ready=1", bus.o_exe_finish, bus.o_acc_ready);
        end
        @(posedge clk);
        #1;
        stim_q.push_back(-24'sd5);
        stim_q.push_back(24'h7FFFFF);
        stim_q.push_back(24'(200 << 7));
        stim_q.push_back(24'h40);
        applyStimulus(1'b0);
        @(negedge clk);
        checks++;
        if (vmask !== 4'hF) begin
            errors++; $display("[TB] FAIL clamp_latency: valid=%b required 1111", vmask);
        end
        checks++;
        if (ldata !== {EXP_0X40, 8'd200, 8'd255, 8'd0}) begin
            errors++; $display("[TB] FAIL clamp_data: got %h required %h", ldata, {EXP_0X40, 8'd200, 8'd255, 8'd0});
        end
        checks++;
        if (laddr !== {12'd3, 12'd2, 12'd1, 12'd0}) begin
            errors++; $display("[TB] FAIL clamp_addr: got %h required %h", laddr, {12'd3, 12'd2, 12'd1, 12'd0});
        end
        checks++;
        if (bus.o_acc_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_ready: got %b required 0", bus.o_acc_ready);
        end
        @(negedge clk);
        checks++;
        if (vmask !== 4'd0 || bus.o_exe_finish !== 1'b1) begin
            errors++; $display("[TB] FAIL pulse_then_finish: valid=%b finish=%b required valid=0000 finish=1", vmask, bus.o_exe_finish);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_partial_group();
        int bad;
        clear_logs();
        do_cfg(7'd3);
        for (int i = 0; i < 7; i++) begin
            stim_q.push_back(ACC_W'(i << 7));
            exp_q.push_back(i);
        end
        stim_q.push_back(24'h40);
        exp_q.push_back(int'(EXP_0X40));
        stim_q.push_back(24'h3F);
        exp_q.push_back(0);
        applyStimulus(1'b0);
        wait_finish("partial_finish");
        checks++;
        if (pix_q.size() != 9) begin
            errors++; $display("[TB] FAIL partial_count: got %0d pixels required 9", pix_q.size());
        end
        checks++;
        bad = scan_stream();
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL partial_content: %0d bad, first idx %0d got addr %0d data %0d required addr %0d data %0d",
                     bad, first_bad, pix_q[first_bad].addr, pix_q[first_bad].data, first_bad, exp_q[first_bad]);
        end
        checks++;
        if (mask_q.size() != 3 || mask_q[mask_q.size() - 1] !== 4'b0001) begin
            errors++; $display("[TB] FAIL partial_mask: got %0d pulses last %b required 3 pulses last 0001",
                               mask_q.size(), mask_q[mask_q.size() - 1]);
        end
        checks++;
        if (idle_bad != 0) begin
            errors++; $display("[TB] FAIL partial_idle_lanes: got %0d nonzero idle lanes required 0", idle_bad);
        end
    endtask

    task automatic test_gaps();
        int bad;
        clear_logs();
        do_cfg(7'd22);
        for (int i = 0; i < 484; i++) begin
            stim_q.push_back(ACC_W'(i << 7));
            exp_q.push_back(i > 255 ? 255 : i);
        end
        applyStimulus(1'b1);
        @(negedge clk);
        checks++;
        if (bus.o_acc_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL gaps_ready_after_last: got %b required 0", bus.o_acc_ready);
        end
        @(posedge clk);
        #1;
        wait_finish("gaps_finish");
        checks++;
        if (pix_q.size() != 484) begin
            errors++; $display("[TB] FAIL gaps_count: got %0d pixels required 484", pix_q.size());
        end
        checks++;
        bad = scan_stream();
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL gaps_content: %0d bad, first idx %0d got addr %0d data %0d required addr %0d data %0d",
                     bad, first_bad, pix_q[first_bad].addr, pix_q[first_bad].data, first_bad, exp_q[first_bad]);
        end
        bad = 0;
        foreach (mask_q[m]) if (mask_q[m] !== 4'hF) bad++;
        checks++;
        if (mask_q.size() != 121 || bad != 0) begin
            errors++; $display("[TB] FAIL gaps_pulses: got %0d pulses (%0d not all-lane) required 121 all-lane", mask_q.size(), bad);
        end
    endtask

    task automatic test_reset_midrun();
        int bad;
        clear_logs();
        do_cfg(7'd32);
        for (int i = 0; i < 11; i++) stim_q.push_back(ACC_W'(i << 7));
        applyStimulus(1'b0);
        // The group-completing sample is offered on the same edge that reset is applied.
        bus.i_acc_valid = 1'b1;
        bus.i_acc_data  = ACC_W'(11 << 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_acc_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (vmask !== 4'd0 || bus.o_acc_ready !== 1'b0 || bus.o_exe_finish !== 1'b0) begin
            errors++; $display("[TB] FAIL midrun_reset: valid=%b ready=%b finish=%b required 0000/0/0",
                               vmask, bus.o_acc_ready, bus.o_exe_finish);
        end
        checks++;
        if (pix_q.size() != 8) begin
            errors++; $display("[TB] FAIL midrun_pre_count: got %0d pixels required 8", pix_q.size());
        end
        @(posedge clk);
        #1;
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            stim_q.push_back(ACC_W'((i + 100) << 7));
            exp_q.push_back(i + 100);
        end
        do_cfg(7'd32);
        applyStimulus(1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (pix_q.size() != 8) begin
            errors++; $display("[TB] FAIL restart_count: got %0d pixels required 8", pix_q.size());
        end
        checks++;
        bad = scan_stream();
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL restart_content: %0d bad, first idx %0d got addr %0d data %0d required addr %0d data %0d",
                     bad, first_bad, pix_q[first_bad].addr, pix_q[first_bad].data, first_bad, exp_q[first_bad]);
        end
    endtask

    task automatic test_ignored_inputs();
        int bad = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        bus.i_acc_valid = 1'b1;
        bus.i_acc_data  = 24'h012345;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.o_acc_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        bus.i_acc_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("[TB] FAIL idle_ready: ready high in %0d idle cycles required 0", bad);
        end
        checks++;
        if (pix_q.size() != 0) begin
            errors++; $display("[TB] FAIL idle_no_output: got %0d pixels required 0", pix_q.size());
        end
        do_cfg(7'd2);
        for (int i = 0; i < 2; i++) begin
            stim_q.push_back(ACC_W'((i + 10) << 7));
            exp_q.push_back(i + 10);
        end
        applyStimulus(1'b0);
        do_cfg(7'd64);
        stim_q.delete();
        for (int i = 2; i < 4; i++) begin
            stim_q.push_back(ACC_W'((i + 10) << 7));
            exp_q.push_back(i + 10);
        end
        applyStimulus(1'b0);
        wait_finish("ignore_cfg_finish");
        checks++;
        bad = scan_stream();
        if (pix_q.size() != 4 || bad != 0) begin
            errors++; $display("[TB] FAIL ignore_cfg_content: got %0d pixels (%0d bad) required 4 at addr 0..3",
                               pix_q.size(), bad);
        end
    endtask

    initial begin
        test_reset();
        test_full_map();
        test_clamp_round();
        test_partial_group();
        test_gaps();
        test_reset_midrun();
        test_ignored_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
